// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit with accumulate mode and valid/ready handshakes
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Y_all,
  output logic             Y_any
);
  logic             valid_q, valid_d, all_q, all_d, any_q, any_d, fire;
  logic [WIDTH-1:0] y_q, y_d, acc_q, acc_d, l, res;
  assign in_ready = !valid_q || out_ready;
  assign fire = in_valid && in_ready;
  always_comb begin
    l = (acc_en && !acc_clr) ? acc_q : A;
    res = op == 3'd0 ? l & B :
          op == 3'd1 ? l | B :
          op == 3'd2 ? l ^ B :
          op == 3'd3 ? ~(l & B) :
          op == 3'd4 ? ~(l | B) :
          op == 3'd5 ? ~(l ^ B) :
          op == 3'd6 ? ~l : l;
    valid_d = fire || (valid_q && !out_ready);
    y_d = fire ? res : y_q;
    all_d = fire ? &res : all_q;
    any_d = fire ? |res : any_q;
    acc_d = (fire && acc_en) ? res : acc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q <= '0;
      all_q <= 1'b0;
      any_q <= 1'b0;
      acc_q <= '0;
    end else begin
      valid_q <= valid_d;
      y_q <= y_d;
      all_q <= all_d;
      any_q <= any_d;
      acc_q <= acc_d;
    end
  end
  assign out_valid = valid_q;
  assign Y = y_q;
  assign Y_all = all_q;
  assign Y_any = any_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vectors with literal expectations plus a per-cycle reference model compare
module tb_logic_unit_pipe;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, acc_en = 0, acc_clr = 0;
  logic [7:0] A = 0, B = 0, Y;
  logic [2:0] op = 0;
  logic in_ready, out_valid, Y_all, Y_any;
  int checks = 0, errors = 0;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .Y_all(Y_all), .Y_any(Y_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  logic m_valid = 0;
  logic [7:0] m_y = 0, m_acc = 0, m_l;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_y = 0; m_acc = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_l = (acc_en && !acc_clr) ? m_acc : A;
      m_y = ref_op(op, m_l, B);
      m_valid = 1;
      if (acc_en) m_acc = m_y;
    end else if (out_ready) m_valid = 0;
  end

  always @(negedge clk) if (rst_n) begin
    check("model_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("model_in_ready", {31'b0, in_ready}, {31'b0, !m_valid || out_ready});
    if (m_valid) begin
      check("model_Y", {24'b0, Y}, {24'b0, m_y});
      check("model_Y_all", {31'b0, Y_all}, {31'b0, &m_y});
      check("model_Y_any", {31'b0, Y_any}, {31'b0, |m_y});
    end
  end

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                      input logic ae, input logic ac);
    in_valid = 1; A = a; B = b; op = o; acc_en = ae; acc_clr = ac;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] y, input logic all, input logic any);
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_Y"}, {24'b0, Y}, {24'b0, y});
    check({name, "_all"}, {31'b0, Y_all}, {31'b0, all});
    check({name, "_any"}, {31'b0, Y_any}, {31'b0, any});
  endtask

  logic [7:0] sweep [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};

  initial begin
    #3;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_Y", {24'b0, Y}, 32'd0);
    check("rst_flags", {30'b0, Y_all, Y_any}, 32'd0);
    #9 rst_n = 1;
    @(posedge clk); #1;
    // single AND beat, then the result drains
    beat(8'hF0, 8'h3C, 3'd0, 0, 0);
    expect_out("t1", 8'h30, 0, 1);
    @(posedge clk); #1;
    check("t1_drain", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      beat(8'hF0, 8'h3C, 3'(i), 0, 0);
      check("t2_sweep", {24'b0, Y}, {24'b0, sweep[i]});
      check("t2_in_ready", {31'b0, in_ready}, 32'd1);
    end
    // accumulate OR; A is ignored once accumulation continues
    beat(8'h01, 8'h02, 3'd1, 1, 1); check("t3_b1", {24'b0, Y}, 32'h03);
    beat(8'h55, 8'h40, 3'd1, 1, 0); check("t3_b2", {24'b0, Y}, 32'h43);
    beat(8'h55, 8'h80, 3'd1, 1, 0); check("t3_b3", {24'b0, Y}, 32'hC3);
    beat(8'h55, 8'h00, 3'd7, 1, 0); check("t3_b4", {24'b0, Y}, 32'hC3);
    beat(8'hAA, 8'h00, 3'd7, 0, 0); check("t4_first", {24'b0, Y}, 32'hAA);
    out_ready = 0; in_valid = 1; A = 8'h55; B = 8'h00; op = 3'd7; acc_en = 0; acc_clr = 0;
    repeat (3) begin
      @(posedge clk); #1;
      check("t4_in_ready", {31'b0, in_ready}, 32'd0);
      check("t4_hold_Y", {24'b0, Y}, 32'hAA);
      check("t4_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1; #1;
    check("t4_release_Y", {24'b0, Y}, 32'hAA);
    check("t4_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    check("t4_pending_Y", {24'b0, Y}, 32'h55);
    check("t4_pending_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    check("t4_drain", {31'b0, out_valid}, 32'd0);
    beat(8'hFF, 8'hFF, 3'd0, 0, 0); expect_out("t5_and", 8'hFF, 1, 1);
    beat(8'hFF, 8'hFF, 3'd4, 0, 0); expect_out("t5_nor", 8'h00, 0, 0);
    // load acc=0xC3 then reset between edges
    beat(8'hC3, 8'h00, 3'd7, 1, 1); expect_out("t6_load", 8'hC3, 1'b0, 1'b1);
    #2 rst_n = 0; #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_Y", {24'b0, Y}, 32'd0);
    check("t6_rst_flags", {30'b0, Y_all, Y_any}, 32'd0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    beat(8'hFF, 8'h04, 3'd1, 1, 0); expect_out("t6_after", 8'h04, 0, 1);
    @(posedge clk); #1;
    check("t6_drain", {31'b0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered bitwise logic unit. It is the successor to the team's single-bit AND cells and generalises them in three ways: WIDTH-bit operands, eight selectable operations, and an accumulate mode that folds a stream of B operands into an internal register. Input and output use valid/ready handshakes, so the unit drops into streaming datapaths with one cycle of latency and full throughput.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
A  input  WIDTH  left operand
B  input  WIDTH  right operand
op  input  3  operation select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT L, 7 PASS L
acc_en  input  1  accumulate mode for this beat
acc_clr  input  1  start a new accumulation (only meaningful with acc_en=1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
Y  output  WIDTH  registered result
Y_all  output  1  registered AND-reduction of Y
Y_any  output  1  registered OR-reduction of Y

Behaviour:
- One clock. Reset is asynchronous and active-low; rst_n=0 forces out_valid=0, Y=0, Y_all=0, Y_any=0 and acc=0 immediately, independent of clk.
- in_ready is combinational: in_ready = !out_valid || out_ready.
- Accept: a beat is accepted on a rising edge with in_valid && in_ready. A, B, op, acc_en and acc_clr are sampled only on accept.
- Left operand: L = (acc_en && !acc_clr) ? acc : A. Right operand: R = B.
- Result: R_res = op(L, R), computed bitwise over WIDTH bits.
  - Op 6 gives ~L; op 7 gives L. B is ignored for both.
- On accept, on the same edge:
  - Y <= R_res; Y_all <= &R_res; Y_any <= |R_res; out_valid <= 1.
  - If acc_en=1, acc <= R_res. If acc_en=0, acc is unchanged and acc_clr is ignored.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, Y, Y_all, Y_any and acc are held and no beat is accepted.
- Completion: out_valid drops on an edge where out_valid && out_ready and no new beat is accepted.
- Simultaneous events: output drain and a new accept on the same edge gives back-to-back results; out_valid stays 1 and Y updates.
- acc is not visible on the ports. It is observed through results; op 7 with acc_en=1, acc_clr=0 reads it back unchanged.
- Reset mid-operation: any pending result is discarded and acc clears. The first beat after reset with acc_en=1 and acc_clr=0 uses acc=0 as L.
- No X propagation: Y must never depend on unsampled inputs.
- WIDTH=1 must work; Y_all = Y_any = Y in that case.
- No internal state other than out_valid, Y, Y_all, Y_any and acc. No state machine beyond the valid flag.

Test Plan:
1. Reset then single beat, WIDTH=8: A=0xF0, B=0x3C, op=0 (AND), out_ready=1 -> next cycle out_valid=1, Y=0x30, Y_all=0, Y_any=1. The following cycle out_valid=0.
2. Op sweep with A=0xF0, B=0x3C, ops 0..7 back-to-back, out_ready=1 -> Y sequence 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0x0F, 0xF0 on consecutive cycles; in_ready stays 1 throughout.
3. Accumulate OR with op=1, out_ready=1:
   - Beat1: acc_en=1, acc_clr=1, A=0x01, B=0x02 -> Y=0x03.
   - Beat2: acc_en=1, acc_clr=0, B=0x40 -> Y=0x43.
   - Beat3: acc_en=1, acc_clr=0, B=0x80 -> Y=0xC3.
   - Beat4: op=7, acc_en=1, acc_clr=0 -> Y=0xC3.
4. Backpressure: accept beat Y=0xAA, hold out_ready=0 for 3 cycles while in_valid=1 with new data -> in_ready=0; Y stays 0xAA; nothing is accepted. Releasing out_ready delivers 0xAA, then the pending beat on the next cycle.
5. Reduction flags: A=0xFF, B=0xFF, op=0 -> Y_all=1, Y_any=1. Then op=4 (NOR) -> Y=0x00, Y_all=0, Y_any=0.
6. Reset mid-operation: with acc=0xC3 and out_valid=1, pulse rst_n=0 between clock edges -> out_valid, Y and flags clear immediately. The next beat with op=1, acc_en=1, acc_clr=0, B=0x04 gives Y=0x04.
